// File: rtl/halve_state_seq.sv
// Iterative GF(2^8) multiply-by-2^-k over 16 AES state bytes; HALVE_STATE_BIDIR_EN adds dir_in for multiply-by-2^k.
// Result valid k+1 cycles after acceptance; one request in flight, result held in DONE until out_ready.
module halve_state_seq #(
    parameter int CNT_W     = 4,
    parameter int MAX_SHIFT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [CNT_W-1:0] shift_in,
`ifdef HALVE_STATE_BIDIR_EN
    input  logic             dir_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             busy
);

    typedef logic [15:0][7:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [CNT_W-1:0] MAX_K = CNT_W'(MAX_SHIFT);

    fsm_e             st, st_nxt;
    state_t           work, work_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] shift_clamped;
    logic             step_dbl;

    // Inverse of xtime under 0x11B: fold the low bit back through the polynomial.
    function automatic logic [7:0] halve_byte(input logic [7:0] y);
        return {y[0], y[7], y[6], y[5], y[4] ^ y[0], y[3] ^ y[0], y[2], y[1] ^ y[0]};
    endfunction

    function automatic logic [7:0] double_byte(input logic [7:0] x);
        return {x[6], x[5], x[4], x[3] ^ x[7], x[2] ^ x[7], x[1], x[0] ^ x[7], x[7]};
    endfunction

    function automatic state_t step_state(input state_t s, input logic dbl);
        state_t r;
        for (int i = 0; i < 16; i++) begin
            r[i] = dbl ? double_byte(s[i]) : halve_byte(s[i]);
        end
        return r;
    endfunction

    assign shift_clamped = (shift_in > MAX_K) ? MAX_K : shift_in;

`ifdef HALVE_STATE_BIDIR_EN
    logic dir_q;

    // Direction is captured at acceptance and held for the whole request.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (st == IDLE && in_valid) begin
            dir_q <= dir_in;
        end
    end

    assign step_dbl = dir_q;
`else
    assign step_dbl = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            work <= '0;
            cnt  <= '0;
        end else begin
            st   <= st_nxt;
            work <= work_nxt;
            cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        work_nxt = work;
        cnt_nxt  = cnt;
        unique case (st)
            IDLE: begin
                if (in_valid) begin
                    work_nxt = data_in;
                    cnt_nxt  = shift_clamped;
                    st_nxt   = (shift_clamped != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                work_nxt = step_state(work, step_dbl);
                cnt_nxt  = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    st_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    st_nxt = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // All outputs decode registered state only, so no input reaches an output combinationally.
    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);
    assign data_out  = (st == DONE) ? work : '0;

endmodule

// File: tb/tb_halve_state_seq.sv
// Randomized bench for halve_state_seq against a polynomial-arithmetic reference model.
module tb_halve_state_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [3:0]   shift_in;
    logic         dir_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    halve_state_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_in  (shift_in),
`ifdef HALVE_STATE_BIDIR_EN
        .dir_in    (dir_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: multiply each byte by x^-1 (or x) modulo 0x11B, k times.
    function automatic logic [127:0] model(input logic [127:0] d, input int k, input logic dbl);
        logic [127:0] s = d;
        int kk = (k > 15) ? 15 : k;
        for (int n = 0; n < kk; n++) begin
            for (int b = 0; b < 16; b++) begin
                int v = int'(s[8*b +: 8]);
                if (dbl) v = (v * 2) ^ (((v & 128) != 0) ? 'h11B : 0);
                else     v = (v ^ (((v & 1) != 0) ? 'h11B : 0)) / 2;
                s[8*b +: 8] = v[7:0];
            end
        end
        return s;
    endfunction

    task automatic run_req(input logic [127:0] d, input int k, input logic dbl,
                           input int hold, output logic [127:0] res);
        int kk = (k > 15) ? 15 : k;
        int lat;
        logic [127:0] exp = model(d, k, dbl);
        in_valid = 1'b1;
        data_in  = d;
        shift_in = 4'(k);
        dir_in   = dbl;
        tick();
        lat = 1;
        // Junk request during RUN/DONE must be ignored.
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        shift_in = 4'($urandom_range(0, 15));
        dir_in   = ~dbl;
        while (!out_valid && lat < 40) begin
            check("in_ready_busy", in_ready, 1'b0);
            tick();
            lat++;
        end
        check("latency", 128'(lat), 128'(kk + 1));
        check("data", data_out, exp);
        res = data_out;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", data_out, exp);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [127:0] res, orig, mid, tmp;
        rst = 1'b1; in_valid = 1'b0; data_in = '0; shift_in = '0;
        dir_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data_out, '0);

        run_req({16{8'h1B}}, 1, 1'b0, 0, res);
        check("halve_1b", res, {16{8'h80}});
        run_req(128'h0201, 1, 1'b0, 0, res);
        check("inv_two", res, 128'h018D);
        run_req({16{8'h80}}, 7, 1'b0, 0, res);
        check("multi_7", res, {16{8'h01}});
        tmp = {$urandom, $urandom, $urandom, $urandom};
        run_req(tmp, 0, 1'b0, 0, res);
        check("k0_passthru", res, tmp);
        run_req({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 5, res);

        // Reset three cycles into a k=15 run.
        in_valid = 1'b1; data_in = {16{8'hA5}}; shift_in = 4'd15;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", data_out, '0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);

        // Reset beats a simultaneous request.
        rst = 1'b1; in_valid = 1'b1; data_in = '1; shift_in = 4'd0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_vs_req_ready", in_ready, 1'b1);
        check("rst_vs_req_busy", busy, 1'b0);

`ifdef HALVE_STATE_BIDIR_EN
        run_req({16{8'h8D}}, 1, 1'b1, 0, res);
        check("double_8d", res, {16{8'h01}});
        orig = {$urandom, $urandom, $urandom, $urandom};
        run_req(orig, 9, 1'b0, 0, mid);
        run_req(mid, 9, 1'b1, 0, res);
        check("round_trip", res, orig);
`else
        orig = '0;
        mid  = '0;
`endif

        for (int t = 0; t < 40; t++) begin
            logic dbl;
`ifdef HALVE_STATE_BIDIR_EN
            dbl = 1'($urandom_range(0, 1));
`else
            dbl = 1'b0;
`endif
            run_req({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 15),
                    dbl, $urandom_range(0, 3), res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
